// File: rtl/servant_spi_wb_bridge.sv
// SPI mode-0 slave that turns host command frames into 32-bit Wishbone burst reads/writes.
// Optional CPU hold output enabled by defining SERVANT_SPI_CPU_HOLD_EN.
module servant_spi_wb_bridge #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic [7:0]  CMD_WRITE   = 8'h02,
   parameter logic [7:0]  CMD_READ    = 8'h03,
   parameter int unsigned DUMMY_BITS  = 8
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_spi_sclk,
   input  logic        i_spi_cs_n,
   input  logic        i_spi_mosi,
   output logic        o_spi_miso,
   output logic [31:0] o_wb_adr,
   output logic [31:0] o_wb_dat,
   output logic [3:0]  o_wb_sel,
   output logic        o_wb_we,
   output logic        o_wb_cyc,
   input  logic [31:0] i_wb_rdt,
   input  logic        i_wb_ack,
   output logic        o_overrun
`ifdef SERVANT_SPI_CPU_HOLD_EN
   ,
   output logic        o_cpu_rst
`endif
);

   localparam logic [7:0] DummyLast = 8'(DUMMY_BITS - 1);

   typedef enum logic [2:0] {
      StIdle, StCmd, StAddr, StWrData, StDummy, StRdData, StIgnore
   } state_e;

   state_e state, state_next;

   logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
   logic        sclk_prev, cs_prev;
   logic        sclk, cs_n, mosi;
   logic        sclk_rise, sclk_fall, cs_fall, cs_rise;

   logic [7:0]  bit_cnt;
   logic [31:0] shift_in, shift_out, hold, addr, req_dat;
   logic [31:0] shift_next;
   logic [7:0]  cmd_byte;
   logic        hold_valid, load_pending, is_read;
   logic        req, req_we, stale, ack, issue, wr_busy;

   assign sclk      = sclk_sync[SYNC_STAGES-1];
   assign cs_n      = cs_sync[SYNC_STAGES-1];
   assign mosi      = mosi_sync[SYNC_STAGES-1];
   assign sclk_rise = sclk & ~sclk_prev;
   assign sclk_fall = ~sclk & sclk_prev;
   assign cs_fall   = ~cs_n & cs_prev;
   assign cs_rise   = cs_n & ~cs_prev;

   assign shift_next = {shift_in[30:0], mosi};
   assign cmd_byte   = shift_next[7:0];
   assign ack        = o_wb_cyc & i_wb_ack;
   assign issue      = req & ~o_wb_cyc & ~cs_rise;
   // A cycle left over from a previous session does not count as a pending write.
   assign wr_busy    = req | (o_wb_cyc & ~stale);

   assign o_wb_sel   = 4'b1111;
   assign o_spi_miso = (state == StRdData) & shift_out[31];

   always_ff @(posedge i_clk) begin
      if (i_rst) state <= StIdle;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (cs_rise) begin
         state_next = StIdle;
      end else begin
         unique case (state)
            StIdle:   if (cs_fall) state_next = StCmd;
            StCmd:    if (sclk_rise && bit_cnt == 8'd7)
                         state_next = (cmd_byte == CMD_WRITE || cmd_byte == CMD_READ) ?
                                      StAddr : StIgnore;
            StAddr:   if (sclk_rise && bit_cnt == 8'd31)
                         state_next = is_read ? StDummy : StWrData;
            StDummy:  if (sclk_rise && bit_cnt == DummyLast) state_next = StRdData;
            default:  ;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sclk_sync    <= '0;
         cs_sync      <= '1;
         mosi_sync    <= '0;
         sclk_prev    <= 1'b0;
         cs_prev      <= 1'b1;
         bit_cnt      <= '0;
         shift_in     <= '0;
         shift_out    <= '0;
         hold         <= '0;
         hold_valid   <= 1'b0;
         load_pending <= 1'b0;
         is_read      <= 1'b0;
         addr         <= '0;
         req          <= 1'b0;
         req_we       <= 1'b0;
         req_dat      <= '0;
         stale        <= 1'b0;
         o_wb_adr     <= '0;
         o_wb_dat     <= '0;
         o_wb_we      <= 1'b0;
         o_wb_cyc     <= 1'b0;
         o_overrun    <= 1'b0;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_spi_sclk};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], i_spi_cs_n};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_spi_mosi};
         sclk_prev <= sclk;
         cs_prev   <= cs_n;

         if (cs_fall) o_overrun <= 1'b0;

         if (ack) begin
            o_wb_cyc <= 1'b0;
            o_wb_we  <= 1'b0;
            if (stale) begin
               stale <= 1'b0;
            end else begin
               addr <= addr + 32'd4;
               if (!o_wb_we) begin
                  hold       <= i_wb_rdt;
                  hold_valid <= 1'b1;
               end
            end
         end else if (issue) begin
            o_wb_cyc <= 1'b1;
            o_wb_we  <= req_we;
            o_wb_adr <= addr;
            if (req_we) o_wb_dat <= req_dat;
            req      <= 1'b0;
         end

         if (cs_rise) begin
            bit_cnt      <= '0;
            shift_in     <= '0;
            shift_out    <= '0;
            hold_valid   <= 1'b0;
            load_pending <= 1'b0;
            req          <= 1'b0;
            stale        <= o_wb_cyc & ~i_wb_ack;
         end else begin
            unique case (state)
               StCmd: if (sclk_rise) begin
                  shift_in <= shift_next;
                  bit_cnt  <= bit_cnt + 8'd1;
                  if (bit_cnt == 8'd7) begin
                     bit_cnt <= '0;
                     is_read <= (cmd_byte == CMD_READ);
                  end
               end
               StAddr: if (sclk_rise) begin
                  shift_in <= shift_next;
                  bit_cnt  <= bit_cnt + 8'd1;
                  if (bit_cnt == 8'd31) begin
                     bit_cnt <= '0;
                     addr    <= {shift_next[31:2], 2'b00};
                     if (is_read) begin
                        req    <= 1'b1;
                        req_we <= 1'b0;
                     end
                  end
               end
               StWrData: if (sclk_rise) begin
                  shift_in <= shift_next;
                  bit_cnt  <= bit_cnt + 8'd1;
                  if (bit_cnt == 8'd31) begin
                     bit_cnt <= '0;
                     if (wr_busy) begin
                        o_overrun <= 1'b1;
                     end else begin
                        req     <= 1'b1;
                        req_we  <= 1'b1;
                        req_dat <= shift_next;
                     end
                  end
               end
               StDummy: if (sclk_rise) begin
                  bit_cnt <= bit_cnt + 8'd1;
                  if (bit_cnt == DummyLast) begin
                     bit_cnt      <= '0;
                     load_pending <= 1'b1;
                  end
               end
               StRdData: begin
                  if (sclk_rise) begin
                     bit_cnt <= bit_cnt + 8'd1;
                     if (bit_cnt == 8'd31) begin
                        bit_cnt      <= '0;
                        load_pending <= 1'b1;
                     end
                  end else if (sclk_fall) begin
                     if (load_pending) begin
                        load_pending <= 1'b0;
                        if (hold_valid) begin
                           shift_out  <= hold;
                           hold_valid <= 1'b0;
                           req        <= 1'b1;
                           req_we     <= 1'b0;
                        end else begin
                           // Underrun: the outstanding read still lands in hold later.
                           shift_out <= 32'hFFFF_FFFF;
                           o_overrun <= 1'b1;
                        end
                     end else begin
                        shift_out <= {shift_out[30:0], 1'b0};
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

`ifdef SERVANT_SPI_CPU_HOLD_EN
   logic       booted;
   logic [1:0] release_cnt;
   logic       cpu_busy;

   assign cpu_busy = ~cs_n | o_wb_cyc;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         booted      <= 1'b0;
         release_cnt <= '0;
         o_cpu_rst   <= 1'b1;
      end else begin
         if (cs_fall) booted <= 1'b1;
         if (cpu_busy)                release_cnt <= 2'd2;
         else if (release_cnt != 2'd0) release_cnt <= release_cnt - 2'd1;
         o_cpu_rst <= ~booted | cpu_busy | (release_cnt != 2'd0);
      end
   end
`endif

endmodule
